// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register map, exception encodings and field positions
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [4:0] {
        EXC_NONE = 5'h00,
        EXC_INT  = 5'h01,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c,
        EXC_ERET = 5'h0e
    } exc_type_e;

    // Bit positions inside the exc_flags input vector
    localparam int FLAG_ADEL_IF = 6;
    localparam int FLAG_RI      = 5;
    localparam int FLAG_OV      = 4;
    localparam int FLAG_SYS     = 3;
    localparam int FLAG_BRK     = 2;
    localparam int FLAG_ADEL_D  = 1;
    localparam int FLAG_ADES    = 0;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    function automatic exc_type_e exc_prio(input logic int_pend, input logic [6:0] flags,
                                           input logic eret);
        if (int_pend)                   return EXC_INT;
        else if (flags[FLAG_ADEL_IF])   return EXC_ADEL;
        else if (flags[FLAG_RI])        return EXC_RI;
        else if (flags[FLAG_OV])        return EXC_OV;
        else if (flags[FLAG_SYS])       return EXC_SYS;
        else if (flags[FLAG_BRK])       return EXC_BP;
        else if (flags[FLAG_ADEL_D])    return EXC_ADEL;
        else if (flags[FLAG_ADES])      return EXC_ADES;
        else if (eret)                  return EXC_ERET;
        else                            return EXC_NONE;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky timer interrupt
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned CNT_DIV = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int DW = (CNT_DIV < 1) ? 1 : $clog2(CNT_DIV + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CNT_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = '0;
        end else if (div_q == DIV_MAX) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        // A Compare write acknowledges the interrupt even if the match is still present
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_except_ctrl.sv
// rtl/cp0_except_ctrl.sv - commit-stage exception prioritisation and CP0 register file
module cp0_except_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned CNT_DIV    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_valid,
    input  logic [31:0] pc_i,
    input  logic        in_dslot,
    input  logic [6:0]  exc_flags,
    input  logic        eret_i,
    input  logic [31:0] bad_addr_i,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] excepttype,
    output logic [31:0] epc_o,
    output logic        flush,
    output logic        timer_int
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [7:0]  ip_q, ip_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic        int_pend, exc_take, eret_take, wr_en;
    exc_type_e   exc_type;
    logic [31:0] status_rd, cause_rd;

    assign int_pend = ie_q & ~exl_q & (|(ip_q[7:2] & im_q[7:2]));

    // Gating with resetn keeps flush low while an in-flight exception is being reset
    assign exc_type   = (inst_valid && resetn) ? exc_prio(int_pend, exc_flags, eret_i) : EXC_NONE;
    assign excepttype = {27'd0, exc_type};
    assign flush      = (exc_type != EXC_NONE);
    assign eret_take  = (exc_type == EXC_ERET);
    assign exc_take   = flush && !eret_take;
    assign wr_en      = cp0_we && !flush;

    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (wr_en && (cp0_waddr == CP0_COUNT)),
        .compare_we_i (wr_en && (cp0_waddr == CP0_COMPARE)),
        .wdata_i      (cp0_wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_d       = {ti | hw_int[5], hw_int[4:0], ip_q[1:0]};
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (exc_take) begin
            exl_d     = 1'b1;
            exccode_d = exc_type;
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = in_dslot ? (pc_i - 32'd4) : pc_i;
                bd_d  = in_dslot;
            end
            if (exc_type == EXC_ADEL)
                badvaddr_d = exc_flags[FLAG_ADEL_IF] ? pc_i : bad_addr_i;
            else if (exc_type == EXC_ADES)
                badvaddr_d = bad_addr_i;
        end else if (eret_take) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (cp0_waddr)
                CP0_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[STATUS_EXL];
                    ie_d  = cp0_wdata[STATUS_IE];
                end
                CP0_CAUSE: ip_d[1:0] = cp0_wdata[9:8];
                CP0_EPC:   epc_d     = cp0_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_q       <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_q       <= ip_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        status_rd             = '0;
        status_rd[STATUS_BEV] = 1'b1;
        status_rd[15:8]       = im_q;
        status_rd[STATUS_EXL] = exl_q;
        status_rd[STATUS_IE]  = ie_q;
        cause_rd              = '0;
        cause_rd[CAUSE_BD]    = bd_q;
        cause_rd[CAUSE_TI]    = ti;
        cause_rd[15:8]        = ip_q;
        cause_rd[6:2]         = exccode_q;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_rd;
            CP0_CAUSE:    cp0_rdata = cause_rd;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign epc_o     = epc_q;
    assign timer_int = ti;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// tb/tb_cp0_except_ctrl.sv - directed self-checking bench for cp0_except_ctrl
module tb_cp0_except_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_valid;
    logic [31:0] pc_i;
    logic        in_dslot;
    logic [6:0]  exc_flags;
    logic        eret_i;
    logic [31:0] bad_addr_i;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [31:0] excepttype;
    logic [31:0] epc_o;
    logic        flush;
    logic        timer_int;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_except_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_valid (inst_valid),
        .pc_i       (pc_i),
        .in_dslot   (in_dslot),
        .exc_flags  (exc_flags),
        .eret_i     (eret_i),
        .bad_addr_i (bad_addr_i),
        .hw_int     (hw_int),
        .cp0_we     (cp0_we),
        .cp0_waddr  (cp0_waddr),
        .cp0_wdata  (cp0_wdata),
        .cp0_raddr  (cp0_raddr),
        .cp0_rdata  (cp0_rdata),
        .excepttype (excepttype),
        .epc_o      (epc_o),
        .flush      (flush),
        .timer_int  (timer_int)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid = 1'b0; pc_i = '0; in_dslot = 1'b0; exc_flags = '0; eret_i = 1'b0;
        bad_addr_i = '0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        inst_valid = 1'b1; cp0_we = 1'b1; cp0_waddr = addr; cp0_wdata = data;
        step();
        clear_inputs();
    endtask

    task automatic do_eret();
        inst_valid = 1'b1; eret_i = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        hw_int = '0; cp0_raddr = 5'd12; resetn = 1'b0;
        #3;
        n_checks++; if (cp0_rdata !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got %h exp %h", cp0_rdata, 32'h0040_0000); end
        n_checks++; if (excepttype !== 32'h0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_type got %h/%b exp 0/0", excepttype, flush); end
        n_checks++; if (epc_o !== 32'h0 || timer_int !== 1'b0) begin n_fail++; $display("FAIL reset_epc_ti got %h/%b exp 0/0", epc_o, timer_int); end
        cp0_raddr = 5'd9; #1;
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h exp 0", cp0_rdata); end
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_sys();
        inst_valid = 1'b1; exc_flags = 7'b000_1000; pc_i = 32'h8000_0100; #1;
        n_checks++; if (excepttype !== 32'h8 || flush !== 1'b1) begin n_fail++; $display("FAIL sys_type got %h/%b exp 8/1", excepttype, flush); end
        step(); clear_inputs();
        n_checks++; if (epc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL sys_epc got %h exp %h", epc_o, 32'h8000_0100); end
        cp0_raddr = 5'd12; #1;
        n_checks++; if (cp0_rdata[1] !== 1'b1) begin n_fail++; $display("FAIL sys_exl got %b exp 1", cp0_rdata[1]); end
        cp0_raddr = 5'd13; #1;
        n_checks++; if (cp0_rdata[6:2] !== 5'h8 || cp0_rdata[31] !== 1'b0) begin n_fail++; $display("FAIL sys_cause got %h exp code 8 bd 0", cp0_rdata); end
        inst_valid = 1'b0; exc_flags = 7'b000_1000; #1;
        n_checks++; if (excepttype !== 32'h0) begin n_fail++; $display("FAIL bubble_type got %h exp 0", excepttype); end
        clear_inputs();
        do_eret();
    endtask

    task automatic test_ov_dslot();
        inst_valid = 1'b1; exc_flags = 7'b001_0000; in_dslot = 1'b1; pc_i = 32'h8000_0204; #1;
        n_checks++; if (excepttype !== 32'hc) begin n_fail++; $display("FAIL ov_type got %h exp c", excepttype); end
        step(); clear_inputs();
        cp0_raddr = 5'd13; #1;
        n_checks++; if (epc_o !== 32'h8000_0200 || cp0_rdata[31] !== 1'b1) begin n_fail++; $display("FAIL ov_epc_bd got %h/%b exp 80000200/1", epc_o, cp0_rdata[31]); end
        inst_valid = 1'b1; eret_i = 1'b1; #1;
        n_checks++; if (excepttype !== 32'he || epc_o !== 32'h8000_0200) begin n_fail++; $display("FAIL eret_type got %h/%h exp e/80000200", excepttype, epc_o); end
        step(); clear_inputs();
        cp0_raddr = 5'd12; #1;
        n_checks++; if (cp0_rdata[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl got %b exp 0", cp0_rdata[1]); end
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b00_0001;
        step();
        cp0_raddr = 5'd13; #1;
        n_checks++; if (cp0_rdata[10] !== 1'b1) begin n_fail++; $display("FAIL int_ip2 got %b exp 1", cp0_rdata[10]); end
        inst_valid = 1'b1; exc_flags = 7'b010_0000; pc_i = 32'h8000_0300; #1;
        n_checks++; if (excepttype !== 32'h1) begin n_fail++; $display("FAIL int_wins got %h exp 1", excepttype); end
        step();
        n_checks++; if (epc_o !== 32'h8000_0300) begin n_fail++; $display("FAIL int_epc got %h exp 80000300", epc_o); end
        pc_i = 32'h8000_0400; #1;
        n_checks++; if (excepttype !== 32'ha) begin n_fail++; $display("FAIL exl_masks_int got %h exp a", excepttype); end
        step(); clear_inputs();
        cp0_raddr = 5'd13; #1;
        n_checks++; if (epc_o !== 32'h8000_0300 || cp0_rdata[6:2] !== 5'ha) begin n_fail++; $display("FAIL nested_epc got %h code %h exp 80000300 code a", epc_o, cp0_rdata[6:2]); end
        hw_int = '0;
        step();
        do_eret();
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_ades_and_regs();
        inst_valid = 1'b1; exc_flags = 7'b000_0001; bad_addr_i = 32'h0000_0003; pc_i = 32'h8000_0500;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (excepttype !== 32'h5) begin n_fail++; $display("FAIL ades_type got %h exp 5", excepttype); end
        step(); clear_inputs();
        cp0_raddr = 5'd8; #1;
        n_checks++; if (cp0_rdata !== 32'h3 || epc_o !== 32'h8000_0500) begin n_fail++; $display("FAIL ades_bva_epc got %h/%h exp 3/80000500", cp0_rdata, epc_o); end
        do_eret();
        cp0_raddr = 5'd14; inst_valid = 1'b1; cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678; #1;
        n_checks++; if (cp0_rdata !== 32'h8000_0500) begin n_fail++; $display("FAIL raw_old got %h exp 80000500", cp0_rdata); end
        step(); clear_inputs();
        n_checks++; if (epc_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mtc0_epc got %h exp 12345678", epc_o); end
        mtc0(5'd8, 32'h0000_FFFF);
        cp0_raddr = 5'd8; #1;
        n_checks++; if (cp0_rdata !== 32'h3) begin n_fail++; $display("FAIL bva_ro got %h exp 3", cp0_rdata); end
        cp0_raddr = 5'd5; #1;
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL unimpl got %h exp 0", cp0_rdata); end
        inst_valid = 1'b1; exc_flags = 7'b110_0000; pc_i = 32'h8000_0600; bad_addr_i = 32'h0000_0077; #1;
        n_checks++; if (excepttype !== 32'h4) begin n_fail++; $display("FAIL adel_if_type got %h exp 4", excepttype); end
        step(); clear_inputs();
        cp0_raddr = 5'd8; #1;
        n_checks++; if (cp0_rdata !== 32'h8000_0600) begin n_fail++; $display("FAIL adel_if_bva got %h exp 80000600", cp0_rdata); end
        do_eret();
    endtask

    task automatic test_timer();
        int n;
        mtc0(5'd11, 32'd5);
        n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL ti_clear got %b exp 0", timer_int); end
        mtc0(5'd9, 32'd0);
        n = 1;
        while (n <= 40) begin
            step();
            if (timer_int === 1'b1) break;
            n++;
        end
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL ti_latency got %0d exp 11", n); end
        cp0_raddr = 5'd9; #1;
        n_checks++; if (cp0_rdata !== 32'd5) begin n_fail++; $display("FAIL ti_count got %0d exp 5", cp0_rdata); end
        cp0_raddr = 5'd13; #1;
        n_checks++; if (cp0_rdata[30] !== 1'b1) begin n_fail++; $display("FAIL cause_ti got %b exp 1", cp0_rdata[30]); end
        mtc0(5'd11, 32'd1000);
        n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL ti_ack got %b exp 0", timer_int); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        step(); step();
        cp0_raddr = 5'd9; #1;
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL count_wrap got %h exp 0", cp0_rdata); end
    endtask

    task automatic test_reset_mid();
        mtc0(5'd9, 32'h0000_1000);
        mtc0(5'd12, 32'h0000_FF01);
        inst_valid = 1'b1; exc_flags = 7'b000_1000; pc_i = 32'h8000_0700; #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pre_reset_flush got %b exp 1", flush); end
        resetn = 1'b0; cp0_raddr = 5'd12; #1;
        n_checks++; if (cp0_rdata !== 32'h0040_0000 || flush !== 1'b0) begin n_fail++; $display("FAIL midreset_status got %h/%b exp 00400000/0", cp0_rdata, flush); end
        cp0_raddr = 5'd9; #1;
        n_checks++; if (cp0_rdata !== 32'h0 || epc_o !== 32'h0) begin n_fail++; $display("FAIL midreset_count_epc got %h/%h exp 0/0", cp0_rdata, epc_o); end
        step(); clear_inputs();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_sys();
        test_ov_dslot();
        test_interrupt();
        test_ades_and_regs();
        test_timer();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
